// File: rtl/voter_match_tally_if.sv
// Bus between the voter front end and the match scorer.
//   start        : one-cycle pulse, clears counters and begins a match
//   result       : voter round result, {tail, tie, win}, expected one-hot
//   result_valid : one-cycle strobe qualifying result
//   busy         : match in progress
//   win_cnt / tail_cnt / tie_cnt / round_cnt : per-match counters
//   match_done   : one-cycle pulse when the match ends
//   match_result : 00 none, 01 win, 10 tail, 11 draw
//   err          : sticky flag, a sampled result was not one-hot
// The master modport drives start/result/result_valid; the slave modport
// (the scorer) drives everything else.
interface voter_match_tally_if #(
  parameter int CNT_W = 4
);
  logic             start;
  logic [2:0]       result;
  logic             result_valid;
  logic             busy;
  logic [CNT_W-1:0] win_cnt;
  logic [CNT_W-1:0] tail_cnt;
  logic [CNT_W-1:0] tie_cnt;
  logic [CNT_W-1:0] round_cnt;
  logic             match_done;
  logic [1:0]       match_result;
  logic             err;

  modport master (
    output start, result, result_valid,
    input  busy, win_cnt, tail_cnt, tie_cnt, round_cnt,
    input  match_done, match_result, err
  );

  modport slave (
    input  start, result, result_valid,
    output busy, win_cnt, tail_cnt, tie_cnt, round_cnt,
    output match_done, match_result, err
  );
endinterface

// File: rtl/voter_match_tally.sv
// Sequential match scorer fed by the four-person combinational voter.
// Samples the one-hot round result on result_valid, counts wins, tails,
// ties and accepted rounds, and ends the match when either side reaches
// ROUNDS_TO_WIN or MAX_ROUNDS rounds have been accepted (draw).
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : voter_match_tally_if slave modport (see interface header)
// Every output is a flop or a decode of the state flop only.
module voter_match_tally #(
  parameter int ROUNDS_TO_WIN = 3,
  parameter int MAX_ROUNDS    = 9,
  parameter int CNT_W         = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  voter_match_tally_if.slave    bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] TARGET = CNT_W'(ROUNDS_TO_WIN);
  localparam logic [CNT_W-1:0] BUDGET = CNT_W'(MAX_ROUNDS);
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

  function automatic logic is_onehot(input logic [2:0] r);
    return (r == 3'b001) || (r == 3'b010) || (r == 3'b100);
  endfunction

  state_t           state_q, state_d;
  logic [CNT_W-1:0] win_q, win_d;
  logic [CNT_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] tie_q, tie_d;
  logic [CNT_W-1:0] round_q, round_d;
  logic             done_q, done_d;
  logic [1:0]       mres_q, mres_d;
  logic             err_q, err_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      win_q   <= '0;
      tail_q  <= '0;
      tie_q   <= '0;
      round_q <= '0;
      done_q  <= 1'b0;
      mres_q  <= 2'b00;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      tail_q  <= tail_d;
      tie_q   <= tie_d;
      round_q <= round_d;
      done_q  <= done_d;
      mres_q  <= mres_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    tail_d  = tail_q;
    tie_d   = tie_q;
    round_d = round_q;
    done_d  = 1'b0;
    mres_d  = mres_q;
    err_d   = err_q;

    // start wins over a coincident result_valid: the result is dropped.
    if (bus.start) begin
      state_d = PLAY;
      win_d   = '0;
      tail_d  = '0;
      tie_d   = '0;
      round_d = '0;
      mres_d  = 2'b00;
      err_d   = 1'b0;
    end else if (state_q == PLAY && bus.result_valid) begin
      if (is_onehot(bus.result)) begin
        win_d   = bus.result[0] ? win_q + ONE  : win_q;
        tie_d   = bus.result[1] ? tie_q + ONE  : tie_q;
        tail_d  = bus.result[2] ? tail_q + ONE : tail_q;
        round_d = round_q + ONE;
        // End test uses post-increment values; a target hit on the last
        // budgeted round outranks the draw.
        if (win_d == TARGET) begin
          mres_d  = 2'b01;
          done_d  = 1'b1;
          state_d = DONE;
        end else if (tail_d == TARGET) begin
          mres_d  = 2'b10;
          done_d  = 1'b1;
          state_d = DONE;
        end else if (round_d == BUDGET) begin
          mres_d  = 2'b11;
          done_d  = 1'b1;
          state_d = DONE;
        end
      end else begin
        // Malformed voter output: flag it, do not count the round.
        err_d = 1'b1;
      end
    end
  end

  assign bus.busy         = (state_q == PLAY);
  assign bus.win_cnt      = win_q;
  assign bus.tail_cnt     = tail_q;
  assign bus.tie_cnt      = tie_q;
  assign bus.round_cnt    = round_q;
  assign bus.match_done   = done_q;
  assign bus.match_result = mres_q;
  assign bus.err          = err_q;

endmodule

// File: tb/tb_voter_match_tally.sv
module tb_voter_match_tally;

  localparam logic [2:0] WIN  = 3'b001;
  localparam logic [2:0] TIE  = 3'b010;
  localparam logic [2:0] TAIL = 3'b100;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  voter_match_tally_if #(.CNT_W(4)) vif ();

  voter_match_tally #(
    .ROUNDS_TO_WIN(3),
    .MAX_ROUNDS   (9),
    .CNT_W        (4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (vif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Compare every output against the expected values.
  task automatic chk_all(input string tag, input int b, input int w,
                         input int ta, input int ti, input int r,
                         input int d, input int m, input int e);
    chk({tag, ".busy"},  int'(vif.busy),         b);
    chk({tag, ".win"},   int'(vif.win_cnt),      w);
    chk({tag, ".tail"},  int'(vif.tail_cnt),     ta);
    chk({tag, ".tie"},   int'(vif.tie_cnt),      ti);
    chk({tag, ".round"}, int'(vif.round_cnt),    r);
    chk({tag, ".done"},  int'(vif.match_done),   d);
    chk({tag, ".mres"},  int'(vif.match_result), m);
    chk({tag, ".err"},   int'(vif.err),          e);
  endtask

  // Drive inputs at the falling edge, then land 1 ns after the rising edge.
  task automatic cyc(input logic s, input logic [2:0] r, input logic v);
    @(negedge clk);
    vif.start        = s;
    vif.result       = r;
    vif.result_valid = v;
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks           = 0;
    errors           = 0;
    rst_n            = 1'b0;
    vif.start        = 1'b0;
    vif.result       = 3'b000;
    vif.result_valid = 1'b0;

    // Reset state
    cyc(0, 3'b000, 0);
    cyc(0, 3'b000, 0);
    chk_all("reset", 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // result_valid in IDLE is ignored
    cyc(0, WIN, 1);
    chk_all("idle_ignore", 0, 0, 0, 0, 0, 0, 0, 0);

    // Match 1: win, tie, win, win
    cyc(1, 3'b000, 0);
    chk_all("m1_start", 1, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, WIN, 1);
    cyc(0, TIE, 1);
    cyc(0, WIN, 1);
    chk_all("m1_r3", 1, 2, 0, 1, 3, 0, 0, 0);
    cyc(0, WIN, 1);
    chk_all("m1_end", 0, 3, 0, 1, 4, 1, 1, 0);
    cyc(0, 3'b000, 0);
    chk_all("m1_hold", 0, 3, 0, 1, 4, 0, 1, 0);

    // Match 2: win/tail x2, tie x4, tail -> tail on round 9
    cyc(1, 3'b000, 0);
    chk_all("m2_start", 1, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, WIN, 1);
    cyc(0, TAIL, 1);
    cyc(0, WIN, 1);
    cyc(0, TAIL, 1);
    cyc(0, TIE, 1);
    cyc(0, TIE, 1);
    cyc(0, TIE, 1);
    cyc(0, TIE, 1);
    chk_all("m2_r8", 1, 2, 2, 4, 8, 0, 0, 0);
    cyc(0, TAIL, 1);
    chk_all("m2_end", 0, 2, 3, 4, 9, 1, 2, 0);

    // Match 3: draw at 9 rounds, then a late result is ignored
    cyc(1, 3'b000, 0);
    cyc(0, WIN, 1);
    cyc(0, TAIL, 1);
    cyc(0, TIE, 1);
    cyc(0, WIN, 1);
    cyc(0, TAIL, 1);
    cyc(0, TIE, 1);
    cyc(0, TIE, 1);
    cyc(0, TIE, 1);
    cyc(0, TIE, 1);
    chk_all("m3_draw", 0, 2, 2, 5, 9, 1, 3, 0);
    cyc(0, WIN, 1);
    chk_all("m3_after", 0, 2, 2, 5, 9, 0, 3, 0);

    // Match 4: non-one-hot results set err, rounds not counted
    cyc(1, 3'b000, 0);
    cyc(0, WIN, 1);
    cyc(0, 3'b011, 1);
    chk_all("m4_bad011", 1, 1, 0, 0, 1, 0, 0, 1);
    cyc(0, 3'b000, 1);
    chk_all("m4_bad000", 1, 1, 0, 0, 1, 0, 0, 1);
    cyc(1, 3'b000, 0);
    chk_all("m4_restart", 1, 0, 0, 0, 0, 0, 0, 0);

    // start with coincident result_valid: start wins, result dropped
    cyc(0, TAIL, 1);
    chk_all("m5_pre", 1, 0, 1, 0, 1, 0, 0, 0);
    cyc(1, WIN, 1);
    chk_all("m5_startprio", 1, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, WIN, 1);
    chk_all("m5_first", 1, 1, 0, 0, 1, 0, 0, 0);

    // Asynchronous reset mid-match at win_cnt=2
    cyc(0, WIN, 1);
    chk_all("m6_w2", 1, 2, 0, 0, 2, 0, 0, 0);
    vif.result_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk_all("m6_async", 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, WIN, 1);
    chk_all("m6_held", 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1, 3'b000, 0);
    chk_all("m6_start", 1, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, WIN, 1);
    chk_all("m6_clean", 1, 1, 0, 0, 1, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Absolute time limit so the bench can never hang.
  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
